// File: rtl/apb_completer_ws.sv
// APB4 completer bridging to a variable-latency register port.
// Decodes an address window, forwards strobes, and flags errors and response timeouts.
module apb_completer_ws #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_SPAN  = 256,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic                    o_req,
  output logic                    o_wr,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_strb,
  input  logic                    i_ack,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    i_err
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned ExtW  = ADDR_WIDTH + 1;
  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(StrbW - 1);

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StWait = 3'b010,
    StResp = 3'b100
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  req_q, req_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      strb_q, strb_d;

  // One extra bit so an address below the base wraps to a huge offset and fails.
  logic [ExtW-1:0] offset_ext;
  logic            in_window, aligned, timed_out;

  assign offset_ext = {1'b0, PADDR} - ExtW'(BASE_ADDR);
  assign in_window  = offset_ext < ExtW'(ADDR_SPAN);
  assign aligned    = (PADDR & AlignMask) == '0;
  assign timed_out  = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

  always_comb begin
    // Defaults are the idle values; states that hold a field reassert it.
    state_d   = StIdle;
    cnt_d     = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    req_d     = 1'b0;
    wr_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    strb_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          if (in_window && aligned) begin
            state_d = StWait;
            req_d   = 1'b1;
            wr_d    = PWRITE;
            addr_d  = offset_ext[ADDR_WIDTH-1:0];
            wdata_d = PWRITE ? PWDATA : '0;
            strb_d  = PWRITE ? PSTRB : '0;
          end else begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (PSEL) begin
          wr_d    = wr_q;
          addr_d  = addr_q;
          wdata_d = wdata_q;
          strb_d  = strb_q;
          if (i_ack) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = i_err;
            prdata_d  = (!wr_q && !i_err) ? i_rdata : '0;
          end else if (timed_out) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d = StWait;
            req_d   = 1'b1;
            cnt_d   = cnt_q + CntW'(1);
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;
  assign o_req   = req_q;
  assign o_wr    = wr_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_strb  = strb_q;

endmodule

// File: doc/apb_completer_ws.md
# apb_completer_ws

APB4 completer with wait-state and error support, the parametrised successor to the fixed-latency APB completer. It bridges an APB requester to a register-bank/peripheral port that may take a variable number of cycles to respond. It decodes a configurable address window, forwards byte strobes, and reports errors on PSLVERR. Error sources are out-of-window access, misalignment, a register-side error and a response timeout.

## Interface
- ADDR_WIDTH, 16, APB address width
- DATA_WIDTH, 16, data width; must be a multiple of 8
- BASE_ADDR, 0, first byte address of the decoded window
- ADDR_SPAN, 256, window size in bytes; legal range is BASE_ADDR to BASE_ADDR+ADDR_SPAN-1
- TIMEOUT, 15, cycles to wait for i_ack before signalling an error; 0 disables the timeout

Ports:
- PCLK  in  1  clock, rising edge
- PRESET  in  1  reset; one clock; reset is asynchronous and active-high
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable (access phase)
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte strobes
- PREADY  out  1  transfer complete
- PRDATA  out  DATA_WIDTH  read data
- PSLVERR  out  1  transfer error; valid only while PREADY=1
- o_req  out  1  register-side request, held until acknowledged
- o_wr  out  1  1 = write, 0 = read
- o_addr  out  ADDR_WIDTH  byte offset, PADDR-BASE_ADDR
- o_wdata  out  DATA_WIDTH  write data
- o_strb  out  DATA_WIDTH/8  byte strobes; forced to 0 on reads
- i_ack  in  1  register side done; one-cycle pulse, sampled only while o_req=1
- i_rdata  in  DATA_WIDTH  read data, valid with i_ack
- i_err  in  1  register-side error, valid with i_ack

## Operation
- All outputs are registered. Reset values:
  - PREADY, PSLVERR, o_req, o_wr = 0
  - PRDATA, o_addr, o_wdata, o_strb = 0
  - state = IDLE, timeout counter = 0
- States are one-hot: IDLE, WAIT, RESP.
- IDLE
  - Setup phase is detected as PSEL=1 with PENABLE=0.
  - On setup, capture PWRITE, PADDR, PWDATA and PSTRB, then evaluate:
    - in_window = (PADDR - BASE_ADDR) < ADDR_SPAN, computed ADDR_WIDTH+1 bits wide so that PADDR < BASE_ADDR fails.
    - aligned = the low $clog2(DATA_WIDTH/8) bits of PADDR are 0.
  - If in_window and aligned: go to WAIT. Set o_req=1 and drive o_addr, o_wr, o_wdata and o_strb; on a read, o_wdata=0 and o_strb=0.
  - Otherwise: go to RESP with PSLVERR=1 and PRDATA=0. o_req is not asserted.
- WAIT
  - o_req and the o_* fields stay stable.
  - The counter increments each cycle while i_ack=0.
  - On i_ack: o_req←0. PRDATA←i_rdata, but only on a read with i_err=0; otherwise 0. PSLVERR←i_err. Go to RESP.
  - TIMEOUT≠0 and counter reaches TIMEOUT with no ack: o_req←0, PSLVERR←1, PRDATA←0, go to RESP.
  - If i_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins.
- RESP
  - PREADY=1 for exactly one cycle, then return to IDLE.
  - On entry to IDLE: PREADY, PSLVERR and PRDATA are cleared, the counter is cleared, and o_wr, o_addr, o_wdata and o_strb return to 0.
- Abort: if PSEL=0 in WAIT or RESP, go to IDLE next cycle.
  - o_req and PREADY are dropped and any pending i_ack is ignored.
  - This is a requester protocol violation; no error is reported.
- Write data reaches the register side only through o_* while o_req=1.
- Reset asserted mid-transfer forces all outputs and state to their reset values immediately, asynchronously.

## Timing
- The setup phase is sampled at edge T0. o_req is high from T0+.
- i_ack sampled at edge Tn gives PREADY high from Tn+ to Tn+1+. The requester completes the transfer at edge Tn+1.
- The minimum in-window transfer has i_ack at T1: PREADY is high T1..T2 and the access phase lasts 2 cycles (1 wait state).
- An out-of-window or misaligned access has PREADY high T0..T1, with no wait state.
- Timeout: PREADY rises TIMEOUT+1 edges after T0.
- Back-to-back transfers: a new setup phase is accepted on the first cycle in IDLE after RESP.

## Test plan
- Write PADDR=0x0010, PWDATA=0xBEEF, PSTRB=2'b11, i_ack 3 cycles after o_req -> o_addr=0x0010, o_wdata=0xBEEF, o_strb=11, o_wr=1. PREADY is high exactly one cycle after the ack, PSLVERR=0.
- Read with BASE_ADDR=0x1000, PADDR=0x1020, i_rdata=0x1234 with i_ack at T1 -> o_addr=0x0020, o_strb=0, PRDATA=0x1234, PREADY high at T1, PSLVERR=0.
- Read PADDR=0x0200 (out of window), then PADDR=0x0011 (misaligned) -> o_req never asserted, PREADY and PSLVERR high at T0+, PRDATA=0.
- Register side never acks, TIMEOUT=15 -> o_req falls, PREADY=1 and PSLVERR=1 sixteen edges after setup. A second transfer then completes normally.
- Register side acks with i_err=1 and i_rdata=0xFFFF on a read -> PSLVERR=1, PRDATA=0.
- Assert PRESET while in WAIT with o_req=1 -> all outputs are 0 immediately. Drop PSEL in WAIT -> o_req is 0 the next cycle and no PREADY pulse occurs.
